// File: rtl/icache_refill_bridge_pkg.sv
// icache_refill_bridge_pkg: shared bus types, AXI encodings and refill FSM states
//   bus32_t / bus256_t  : beat- and line-wide data types
//   AXI_*               : AXI4 burst/size/response encodings used by the bridge
//   refill_state_t      : IDLE -> AR -> R -> RET refill sequence
package icache_refill_bridge_pkg;
  typedef logic [31:0]  bus32_t;
  typedef logic [255:0] bus256_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  typedef enum logic [1:0] {IDLE, AR, R, RET} refill_state_t;
endpackage

// File: rtl/icache_refill_bridge.sv
// icache_refill_bridge: turns an icache line miss into one AXI4 INCR read burst and returns the line
//   clk, reset          : clock, synchronous active-high reset
//   i_rd_req/i_rd_addr  : icache line request (level) and any byte address within the line
//   o_ret_valid         : one-cycle pulse, o_ret_data/o_ret_err valid
//   o_ret_data/o_ret_err: assembled line (beat i at [32i+31:32i]) and sticky error flag
//   o_ar*/i_arready     : AXI read-address channel (line-aligned INCR burst of BEATS beats)
//   i_r*/o_rready       : AXI read-data channel (i_rid ignored, single outstanding burst)
module icache_refill_bridge
  import icache_refill_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 8,
  parameter int ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_rd_req,
  input  logic [ADDR_W-1:0]       i_rd_addr,
  output logic                    o_ret_valid,
  output logic [BEATS*DATA_W-1:0] o_ret_data,
  output logic                    o_ret_err,
  output logic [ID_W-1:0]         o_arid,
  output logic [ADDR_W-1:0]       o_araddr,
  output logic [7:0]              o_arlen,
  output logic [2:0]              o_arsize,
  output logic [1:0]              o_arburst,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  input  logic [ID_W-1:0]         i_rid,
  input  logic [DATA_W-1:0]       i_rdata,
  input  logic [1:0]              i_rresp,
  input  logic                    i_rlast,
  input  logic                    i_rvalid,
  output logic                    o_rready
);
  localparam int LINE_BITS = BEATS * DATA_W;
  localparam int OFF_W     = $clog2(LINE_BITS / 8);
  localparam int CNT_W     = $clog2(BEATS);
  refill_state_t        r_state;
  logic [CNT_W-1:0]     r_beat_cnt;
  logic [ADDR_W-1:0]    r_line_addr;
  logic [LINE_BITS-1:0] r_line;
  logic                 r_err;
  logic                 r_arvalid;
  logic                 r_rready;
  logic                 r_ret_valid;
  logic                 w_hit;
  logic                 w_unused;
  // The line is only handed back if the icache is still asking for this very line.
  assign w_hit    = i_rd_req && (i_rd_addr[ADDR_W-1:OFF_W] == r_line_addr[ADDR_W-1:OFF_W]);
  assign w_unused = ^{i_rid, i_rd_addr[OFF_W-1:0]};
  assign o_ret_valid = r_ret_valid;
  assign o_ret_data  = r_line;
  assign o_ret_err   = r_err;
  assign o_arid      = AXI_ID;
  assign o_araddr    = r_line_addr;
  assign o_arlen     = 8'(BEATS - 1);
  assign o_arsize    = AXI_SIZE_4B;
  assign o_arburst   = AXI_BURST_INCR;
  assign o_arvalid   = r_arvalid;
  assign o_rready    = r_rready;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_line_addr <= '0;
      r_line      <= '0;
      r_err       <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_ret_valid <= 1'b0;
    end else begin
      r_ret_valid <= 1'b0;
      case (r_state)
        // The icache still holds rd_req during the ret_valid cycle; ignore it then to avoid a duplicate refill.
        IDLE: if (i_rd_req && !r_ret_valid) begin
          r_line_addr <= {i_rd_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          r_beat_cnt  <= '0;
          r_err       <= 1'b0;
          r_arvalid   <= 1'b1;
          r_state     <= AR;
        end
        AR: if (i_arready) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= R;
        end
        // rlast alone ends the burst; a short burst leaves stale slots and is flagged as an error.
        R: if (i_rvalid) begin
          r_line[int'(r_beat_cnt)*DATA_W +: DATA_W] <= i_rdata;
          r_beat_cnt <= r_beat_cnt + 1'b1;
          r_err      <= r_err || (i_rresp != AXI_RESP_OKAY) || (i_rlast && r_beat_cnt != CNT_W'(BEATS - 1));
          if (i_rlast) begin
            r_rready <= 1'b0;
            r_state  <= RET;
          end
        end
        RET: begin
          r_ret_valid <= w_hit;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_refill_bridge.sv
// tb_icache_refill_bridge: randomized refill transactions checked against a line-level reference model
module tb_icache_refill_bridge;
  logic         clk = 1'b0;
  logic         reset;
  logic         i_rd_req;
  logic [31:0]  i_rd_addr;
  logic         o_ret_valid;
  logic [255:0] o_ret_data;
  logic         o_ret_err;
  logic [3:0]   o_arid;
  logic [31:0]  o_araddr;
  logic [7:0]   o_arlen;
  logic [2:0]   o_arsize;
  logic [1:0]   o_arburst;
  logic         o_arvalid;
  logic         i_arready;
  logic [3:0]   i_rid;
  logic [31:0]  i_rdata;
  logic [1:0]   i_rresp;
  logic         i_rlast;
  logic         i_rvalid;
  logic         o_rready;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] mdl_line [8];
  icache_refill_bridge dut (
    .clk(clk), .reset(reset), .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
    .o_ret_valid(o_ret_valid), .o_ret_data(o_ret_data), .o_ret_err(o_ret_err),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready), .i_rid(i_rid),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .o_rready(o_rready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] mdl_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = mdl_line[i];
    return v;
  endfunction
  task automatic wait_ar(input logic [31:0] exp_araddr, output logic ok);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!o_arvalid && c < 20);
    chk("arvalid_seen", o_arvalid, 1'b1);
    ok = o_arvalid;
    chk("araddr", o_araddr, exp_araddr);
    chk("arlen", o_arlen, 8'd7);
    chk("arsize", o_arsize, 3'b010);
    chk("arburst", o_arburst, 2'b01);
    chk("arid", o_arid, 4'd0);
  endtask
  // mode: 0 held request, 1 drop rd_req, 2 switch to another line; applied after beat cb (cb<0: during AR)
  task automatic run_txn(input logic [31:0] addr, input int d, input int g, input int last,
                         input int eb, input int mode, input int cb, input logic [31:0] base);
    int t0, seen, m;
    logic fresh, ok, exp_err;
    logic [31:0] exp_araddr;
    exp_araddr = {addr[31:5], 5'b0};
    m = (cb > last) ? 0 : mode;
    fresh = !i_rd_req;
    @(negedge clk);
    i_rd_req = 1'b1;
    i_rd_addr = addr;
    t0 = cyc;
    wait_ar(exp_araddr, ok);
    if (!ok) begin
      i_rd_req = 1'b0;
      return;
    end
    if (m == 1 && cb < 0) i_rd_req = 1'b0;
    if (m == 2 && cb < 0) i_rd_addr = addr ^ 32'h100;
    repeat (d) begin
      @(negedge clk);
      chk("arvalid_hold", o_arvalid, 1'b1);
      chk("araddr_hold", o_araddr, exp_araddr);
    end
    i_arready = 1'b1;
    @(negedge clk);
    i_arready = 1'b0;
    exp_err = (last != 7);
    for (int i = 0; i <= last; i++) begin
      repeat (g) begin
        chk("rready_gap", o_rready, 1'b1);
        chk("arvalid_low_r", o_arvalid, 1'b0);
        @(negedge clk);
      end
      i_rvalid = 1'b1;
      i_rdata = (base != 0) ? base + 32'(i) : $urandom;
      i_rresp = (i == eb) ? 2'b10 : 2'b00;
      i_rlast = (i == last);
      mdl_line[i] = i_rdata;
      exp_err = exp_err || (i == eb);
      chk("rready_beat", o_rready, 1'b1);
      @(negedge clk);
      i_rvalid = 1'b0;
      i_rlast = 1'b0;
      i_rresp = 2'b00;
      if (m == 1 && i == cb) i_rd_req = 1'b0;
      if (m == 2 && i == cb) i_rd_addr = addr ^ 32'h100;
    end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (o_ret_valid) begin
        seen++;
        chk("ret_data", o_ret_data, mdl_vec());
        chk("ret_err", o_ret_err, exp_err);
        if (fresh) chk("ret_latency", cyc - t0, 4 + d + last * (g + 1) + g);
      end else if (seen != 0) i_rd_req = 1'b0;
      if (m != 2) chk("no_dup_ar", o_arvalid, 1'b0);
      @(negedge clk);
    end
    chk("ret_count", seen, (m == 0) ? 1 : 0);
    if (m != 2) i_rd_req = 1'b0;
  endtask
  task automatic reset_mid_r(input logic [31:0] addr);
    logic ok;
    @(negedge clk);
    i_rd_req = 1'b1;
    i_rd_addr = addr;
    wait_ar({addr[31:5], 5'b0}, ok);
    i_arready = 1'b1;
    @(negedge clk);
    i_arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_rvalid = 1'b1;
      i_rdata = $urandom;
      @(negedge clk);
    end
    chk("rready_before_rst", o_rready, 1'b1);
    reset = 1'b1;
    i_rvalid = 1'b0;
    i_rd_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) mdl_line[i] = '0;
    chk("rst_arvalid", o_arvalid, 1'b0);
    chk("rst_rready", o_rready, 1'b0);
    chk("rst_ret_valid", o_ret_valid, 1'b0);
    chk("rst_ret_data", o_ret_data, mdl_vec());
    chk("rst_araddr", o_araddr, 32'd0);
  endtask
  initial begin
    int mode, last, eb, cb;
    logic [31:0] a;
    reset = 1'b1;
    i_rd_req = 1'b0;
    i_rd_addr = '0;
    i_arready = 1'b0;
    i_rid = '0;
    i_rdata = '0;
    i_rresp = '0;
    i_rlast = 1'b0;
    i_rvalid = 1'b0;
    for (int i = 0; i < 8; i++) mdl_line[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_arvalid", o_arvalid, 1'b0);
    chk("reset_rready", o_rready, 1'b0);
    chk("reset_ret_valid", o_ret_valid, 1'b0);
    chk("reset_ret_err", o_ret_err, 1'b0);
    chk("reset_ret_data", o_ret_data, 256'd0);
    chk("reset_araddr", o_araddr, 32'd0);
    reset = 1'b0;
    run_txn(32'h1C00_0014, 0, 0, 7, -1, 0, 0, 32'h1000);
    chk("single_lo", o_ret_data[31:0], 32'h1000);
    chk("single_hi", o_ret_data[255:224], 32'h1007);
    run_txn(32'h2000_1234, 5, 2, 7, -1, 0, 0, 32'h0);
    run_txn(32'h3000_0088, 1, 0, 7, -1, 1, 3, 32'h0);
    run_txn(32'h0000_2040, 0, 0, 7, -1, 0, 0, 32'h0);
    run_txn(32'h4000_00E0, 0, 1, 7, 5, 0, 0, 32'h0);
    run_txn(32'h5000_0100, 0, 0, 4, -1, 0, 0, 32'h0);
    run_txn(32'h6000_0004, 2, 0, 7, -1, 1, -1, 32'h0);
    run_txn(32'h7000_0040, 0, 0, 7, -1, 2, 2, 32'h0);
    run_txn(32'h7000_0140, 1, 0, 7, -1, 0, 0, 32'h0);
    reset_mid_r(32'h8000_0020);
    run_txn(32'h8000_0020, 0, 0, 7, -1, 0, 0, 32'h0);
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      mode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      last = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 7;
      eb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1;
      cb = $urandom_range(0, 8) - 1;
      run_txn(a, $urandom_range(0, 3), $urandom_range(0, 2), last, eb, mode, cb, 32'h0);
      if (mode == 2 && cb <= last) run_txn(a ^ 32'h100, 0, 0, 7, -1, 0, 0, 32'h0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
